seq_gen: RTL and testbench

Colour-sequence generator for the Simon Says game, directly downstream of the 32-bit seed generator. It latches the seed on request from the game FSM and expands it with a 32-bit Galois LFSR into a deterministic stream of 2-bit colours. It replays the first `round_len` colours on each `start`, one colour per valid/ready handshake, to the display/check logic. Every replay restarts from the latched seed, so round N+1 always extends round N by exactly one colour.

---
 rtl/seq_gen.sv | 130 +++++++++++++
 tb/tb_seq_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Simon Says colour-sequence generator: latches a seed, expands it with a 32-bit Galois LFSR
// and replays the first round_len colours over a valid/ready handshake. Option: SEQGEN_NO_REPEAT_EN.
module seq_gen #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      seed,
   input  logic             load,
   input  logic             start,
   input  logic             extend,
   output logic [1:0]       colour,
   output logic             colour_valid,
   input  logic             colour_ready,
   output logic             last,
   output logic             done,
   output logic             busy,
   output logic [LEN_W-1:0] round_len
);

   localparam logic [31:0] SAFE_SEED = 32'hACE1_2021;
   localparam logic [31:0] TAPS      = 32'h8020_0003;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t           state_q, state_d;
   logic [31:0]      base_q, base_d;
   logic [31:0]      work_q, work_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] round_len_q, round_len_d;
   logic [1:0]       colour_q, colour_d;
   logic             colour_valid_q, colour_valid_d;
   logic             done_q, done_d;
   logic             busy_q;
   logic [31:0]      base_step, work_step;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] n;
      n = {1'b0, s[31:1]};
      if (s[0]) n = n ^ TAPS;
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         base_q         <= SAFE_SEED;
         work_q         <= '0;
         idx_q          <= '0;
         round_len_q    <= LEN_W'(1);
         colour_q       <= '0;
         colour_valid_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         work_q         <= work_d;
         idx_q          <= idx_d;
         round_len_q    <= round_len_d;
         colour_q       <= colour_d;
         colour_valid_q <= colour_valid_d;
         done_q         <= done_d;
         busy_q         <= (state_d == PLAY);
      end
   end

   // load wins over everything; extend/start only act from IDLE, and a same-cycle extend lengthens this replay
   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      work_d         = work_q;
      idx_d          = idx_q;
      round_len_d    = round_len_q;
      colour_d       = colour_q;
      colour_valid_d = colour_valid_q;
      done_d         = 1'b0;
      base_step      = lfsr_step(base_q);
      work_step      = lfsr_step(work_q);

      if (load) begin
         base_d         = (seed == 32'd0) ? SAFE_SEED : seed;
         round_len_d    = LEN_W'(1);
         colour_valid_d = 1'b0;
         state_d        = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (extend && (round_len_q < LEN_W'(MAX_LEN)))
                  round_len_d = round_len_q + LEN_W'(1);
               if (start) begin
                  work_d         = base_step;
                  colour_d       = base_step[1:0];
                  idx_d          = '0;
                  colour_valid_d = 1'b1;
                  state_d        = PLAY;
               end
            end
            PLAY: begin
               if (colour_valid_q && colour_ready) begin
                  if (idx_q == round_len_q - LEN_W'(1)) begin
                     colour_valid_d = 1'b0;
                     done_d         = 1'b1;
                     state_d        = IDLE;
                  end else begin
                     work_d   = work_step;
                     colour_d = work_step[1:0];
`ifdef SEQGEN_NO_REPEAT_EN
                     if (work_step[1:0] == colour_q) colour_d = work_step[1:0] + 2'd1;
`endif
                     idx_d    = idx_q + LEN_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      colour       = colour_q;
      colour_valid = colour_valid_q;
      done         = done_q;
      busy         = busy_q;
      round_len    = round_len_q;
      last         = colour_valid_q && (idx_q == round_len_q - LEN_W'(1));
   end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: a reference LFSR model queues expected colours on every start,
// and they are popped and compared as the DUT hands colours over.
module tb_seq_gen;

   localparam int MAX_LEN = 32;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [31:0]      seed = '0;
   logic             load = 1'b0;
   logic             start = 1'b0;
   logic             extend = 1'b0;
   logic [1:0]       colour;
   logic             colour_valid;
   logic             colour_ready = 1'b0;
   logic             last;
   logic             done;
   logic             busy;
   logic [LEN_W-1:0] round_len;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model_base = 32'hACE1_2021;
   int          model_len  = 1;
   bit          model_busy = 0;
   logic [1:0]  exp_q[$];

   seq_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .seed(seed), .load(load), .start(start), .extend(extend),
      .colour(colour), .colour_valid(colour_valid), .colour_ready(colour_ready),
      .last(last), .done(done), .busy(busy), .round_len(round_len)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] model_step(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 32'h8020_0003;
      return n;
   endfunction

   task automatic pushExpected();
      logic [31:0] s;
      logic [1:0]  c, prev;
      s = model_base;
      prev = '0;
      for (int i = 0; i < model_len; i++) begin
         s = model_step(s);
         c = s[1:0];
`ifdef SEQGEN_NO_REPEAT_EN
         if (i > 0 && c == prev) c = c + 2'd1;
`endif
         prev = c;
         exp_q.push_back(c);
      end
   endtask

   // Drive one cycle of control inputs and advance the reference model accordingly
   task automatic applyStimulus(input bit do_load, input logic [31:0] s, input bit do_start, input bit do_extend);
      @(negedge clk);
      load = do_load; seed = s; start = do_start; extend = do_extend;
      if (do_load) begin
         model_base = (s == 32'd0) ? 32'hACE1_2021 : s;
         model_len  = 1;
         model_busy = 0;
         exp_q.delete();
      end else if (!model_busy) begin
         if (do_extend && model_len < MAX_LEN) model_len++;
         if (do_start) begin
            pushExpected();
            model_busy = 1;
         end
      end
      @(posedge clk);
      #1;
      load = 0; start = 0; extend = 0;
   endtask

   task automatic runReplay(input logic [31:0] pat, input int pat_len);
      int cyc = 0;
      bit fin = 0;
      logic [1:0] exp_c;
      while (!fin && cyc < 200) begin
         @(negedge clk);
         colour_ready = (cyc < pat_len) ? pat[cyc] : 1'b1;
         if (!colour_valid || exp_q.size() == 0) begin
            checkOutput("valid_in_play", {31'd0, colour_valid}, 32'd1);
            fin = 1;
         end else if (colour_ready) begin
            exp_c = exp_q.pop_front();
            checkOutput("colour", {30'd0, colour}, {30'd0, exp_c});
            checkOutput("last", {31'd0, last}, {31'd0, exp_q.size() == 0});
            checkOutput("busy", {31'd0, busy}, 32'd1);
            if (exp_q.size() == 0) fin = 1;
         end else begin
            checkOutput("colour_hold", {30'd0, colour}, {30'd0, exp_q[0]});
            checkOutput("last_hold", {31'd0, last}, {31'd0, exp_q.size() == 1});
         end
         cyc++;
      end
      if (!fin) checkOutput("replay_timeout", 32'd0, 32'd1);
      @(negedge clk);
      colour_ready = 0;
      checkOutput("done", {31'd0, done}, 32'd1);
      checkOutput("valid_after_done", {31'd0, colour_valid}, 32'd0);
      @(negedge clk);
      checkOutput("done_pulse", {31'd0, done}, 32'd0);
      checkOutput("busy_after", {31'd0, busy}, 32'd0);
      model_busy = 0;
      exp_q.delete();
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_colour"}, {30'd0, colour}, 32'd0);
      checkOutput({tag, "_valid"}, {31'd0, colour_valid}, 32'd0);
      checkOutput({tag, "_last"}, {31'd0, last}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_len"}, 32'(round_len), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      checkIdleOutputs("reset");

      // seed 1, length 5: 3,2,1,3,2
      applyStimulus(1, 32'h1, 0, 0);
      repeat (4) applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("len5", 32'(round_len), 32'd5);
      applyStimulus(0, 0, 1, 0);
      runReplay(32'hFFFF_FFFF, 32);

      // seed 7, length 4
      applyStimulus(1, 32'h7, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0);
      runReplay(32'hFFFF_FFFF, 32);

      // zero seed falls back to the safe seed
      applyStimulus(1, 32'h0, 0, 0);
      applyStimulus(0, 0, 1, 0);
      runReplay(32'hFFFF_FFFF, 32);

      // seed 3, length 4, ready pattern 1,0,0,1,1,0,1
      applyStimulus(1, 32'h3, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0);
      runReplay(32'h0000_0059, 7);

      // extend and start together: replay uses length 5
      applyStimulus(0, 0, 1, 1);
      runReplay(32'hFFFF_FFFF, 32);
      checkOutput("len_after_ext_start", 32'(round_len), 32'd5);

      // extend during PLAY is ignored, start during PLAY ignored
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 1);
      @(negedge clk);
      checkOutput("len_ext_in_play", 32'(round_len), 32'd5);
      runReplay(32'hFFFF_FFFF, 32);

      // load mid-replay while colour 2 is presented
      applyStimulus(0, 0, 1, 0);
      @(negedge clk);
      colour_ready = 1;
      checkOutput("abort_c1", {30'd0, colour}, {30'd0, exp_q.pop_front()});
      @(negedge clk);
      colour_ready = 0;
      checkOutput("abort_c2", {30'd0, colour}, {30'd0, exp_q[0]});
      checkOutput("abort_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1, 32'h1234_5678, 0, 0);
      @(negedge clk);
      checkOutput("abort_valid", {31'd0, colour_valid}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_busy_after", {31'd0, busy}, 32'd0);
      checkOutput("abort_len", 32'(round_len), 32'd1);
      @(negedge clk);
      checkOutput("abort_done_late", {31'd0, done}, 32'd0);

      // 40 extends saturate at MAX_LEN, then a full-length replay
      repeat (40) applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("len_saturate", 32'(round_len), 32'd32);
      applyStimulus(0, 0, 1, 0);
      runReplay(32'hFFFF_FFFF, 32);

      // reset mid-replay, then replay from the safe seed
      applyStimulus(0, 0, 1, 0);
      @(negedge clk);
      colour_ready = 1;
      reset = 0;
      @(posedge clk);
      #1 reset = 1;
      colour_ready = 0;
      model_base = 32'hACE1_2021;
      model_len  = 1;
      model_busy = 0;
      exp_q.delete();
      @(negedge clk);
      checkIdleOutputs("mid_reset");
      applyStimulus(0, 0, 1, 0);
      runReplay(32'hFFFF_FFFF, 32);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
